cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 10-bit CPU, sitting directly upstream of the 4:1 register-read mux.
- Fetches 10-bit instructions over a req/ack instruction-memory port and decodes them.
- Drives the mux select `sw[1:0]` plus register-file write, write-back source, ALU operand latch and ALU op strobes.
- Owns the 8-bit program counter and the HALT condition.

Parameters:
- PC_W, 8, program-counter / instruction-address width.
- IW, 10, instruction and datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  IW  instruction word, sampled when imem_req && imem_ack.
- sw  out  2  register-read mux select (A=00, B=01, C=10, D=11).
- opa_ld  out  1  latch mux output into ALU operand-A register.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- wb_sel  out  2  write-back source: 00 MUX, 01 IMM, 10 ALU.
- wb_rd  out  2  destination register index.
- reg_we  out  1  register-file write enable, one cycle per write.
- imm  out  IW  zero-extended imm4.
- halted  out  1  high in HALT.

Behaviour:
- One clock domain. Reset is synchronous, active-low, and clocked by clk.
- While rst_n=0, at the clock edge: state<=FETCH, pc<=0, ir<=0.
- All outputs are decoded from the registered state and ir (Moore). While rst_n=0 all outputs are forced to 0, imem_req included.
- Reset asserted mid-instruction aborts it; a pending reg_we is dropped.
- Instruction format: ir[9:8]=op, ir[7:6]=rd, ir[5:4]=rs, ir[3:0]=imm4.
- op 00 MOV rd,rs: rd <= reg[rs].
- op 01 LDI rd,imm4: rd <= {6'b0, imm4}.
- op 10 ALU rd,rs: rd <= rd alu_op(imm4[1:0]) rs. imm4[3:2] is ignored.
- op 11 JMP: pc <= {rd,rs,imm4}. Special case: rd=11 and rs=11 is HALT, whatever imm4 holds, so targets 0xF0–0xFF cannot be reached.
- FETCH: imem_req=1.
  - If imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps 0xFF->0x00), go to DECODE.
  - Otherwise stay in FETCH with no limit on wait cycles; pc is held.
- DECODE: no strobes.
  - MOV/LDI -> WB.
  - ALU -> EXEC_A.
  - JMP: pc<=target, go to FETCH.
  - HALT -> HALT.
- EXEC_A (ALU only): sw=rd, opa_ld=1, then go to WB.
- WB: reg_we=1, wb_rd=rd, then go to FETCH.
  - MOV: sw=rs, wb_sel=00.
  - LDI: wb_sel=01; sw is don't-care, driven 00.
  - ALU: sw=rs, wb_sel=10, alu_op=imm4[1:0].
- HALT: halted=1, all strobes 0, imem_req=0. Only rst_n leaves HALT.
- Latency with single-cycle ack:
  - MOV/LDI: 3 cycles.
  - ALU: 4 cycles.
  - JMP: 2 cycles.
- Outside WB: reg_we=0. Outside FETCH: imem_req=0. Outside EXEC_A: opa_ld=0. Idle values: sw=00, wb_sel=00, alu_op=00.
- imem_rdata is ignored when imem_ack=0 or the state is not FETCH.
- imm is valid whenever ir holds an LDI; it is consumed only in WB.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: FETCH, DECODE, EXEC_A, WB, HALT;
  - opcode constants: OP_MOV, OP_LDI, OP_ALU, OP_JMP;
  - ALU op codes;
  - WB_SEL codes;
  - field-slice constants.
- Optional sub-module cpu_decode: combinational ir -> {op, rd, rs, imm4, is_halt}. The FSM and pc stay in cpu_ctrl_seq.

Test Plan:
- Reset, then rst_n=1 with imem_ack=1 and rdata=10'b01_10_00_0101 (LDI C,5) -> cycle 3: reg_we=1, wb_rd=10, wb_sel=01, imm=10'd5; next cycle imem_addr=1.
- ALU 10'b10_01_11_0001 (B<=B-D) -> EXEC_A: sw=01, opa_ld=1; WB: sw=11, alu_op=01, wb_sel=10, reg_we=1, wb_rd=01.
- imem_ack held low 5 cycles in FETCH -> imem_req=1 throughout, imem_addr constant, no state change; ack on cycle 6 -> DECODE.
- JMP 10'b11_00_10_0011 -> next fetch imem_addr=0x23. pc=0xFF fetch of MOV -> pc wraps to 0x00.
- HALT 10'b11_11_11_0000 -> halted=1, imem_req=0 for 20 cycles; rst_n low 1 cycle -> halted=0, imem_addr=0.
- rst_n pulsed low during EXEC_A of an ALU instruction -> reg_we never asserts; FETCH restarts at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 10-bit CPU control path: FSM states, opcodes, ALU/WB codes, field slices.
// Pure definitions; no logic, no latency, no flow control.
// Imported by cpu_decode and cpu_ctrl_seq.
package cpu_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC_A = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WB_MUX = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b10;

  localparam int OP_HI  = 9;
  localparam int OP_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm4;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Splits an instruction word into its fields and flags the HALT encoding.
// Latency: purely combinational. Backpressure: none.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [9:0] ir,
  output dec_t       dec
);

  always_comb begin
    dec.op      = ir[OP_HI:OP_LO];
    dec.rd      = ir[RD_HI:RD_LO];
    dec.rs      = ir[RS_HI:RS_LO];
    dec.imm4    = ir[IMM_HI:IMM_LO];
    // JMP with rd=rs=3 is HALT regardless of imm4
    dec.is_halt = (ir[OP_HI:OP_LO] == OP_JMP) && (ir[RD_HI:RD_LO] == 2'b11)
                  && (ir[RS_HI:RS_LO] == 2'b11);
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc, ir and HALT; drives mux select and datapath strobes.
// Latency with 1-cycle ack: JMP 2, MOV/LDI 3, ALU 4 cycles.
// Backpressure: FETCH waits indefinitely for imem_ack with pc held; outputs are Moore, zeroed while rst_n=0.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [1:0]      sw,
  output logic            opa_ld,
  output logic [1:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic [1:0]      wb_rd,
  output logic            reg_we,
  output logic [IW-1:0]   imm,
  output logic            halted
);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [IW-1:0]   ir;
  dec_t            dec;

  cpu_decode u_decode (
    .ir  (ir[9:0]),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec.is_halt) begin
            state <= ST_HALT;
          end else begin
            case (dec.op)
              OP_ALU: state <= ST_EXEC_A;
              OP_JMP: begin
                pc    <= PC_W'({dec.rd, dec.rs, dec.imm4});
                state <= ST_FETCH;
              end
              default: state <= ST_WB;
            endcase
          end
        end
        ST_EXEC_A: state <= ST_WB;
        ST_WB:     state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    sw        = 2'b00;
    opa_ld    = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_MUX;
    wb_rd     = 2'b00;
    reg_we    = 1'b0;
    imm       = '0;
    halted    = 1'b0;
    if (rst_n) begin
      imem_addr = pc;
      imm       = IW'(dec.imm4);
      case (state)
        ST_FETCH:  imem_req = 1'b1;
        ST_EXEC_A: begin
          sw     = dec.rd;
          opa_ld = 1'b1;
        end
        ST_WB: begin
          reg_we = 1'b1;
          wb_rd  = dec.rd;
          case (dec.op)
            OP_LDI: wb_sel = WB_IMM;
            OP_ALU: begin
              sw     = dec.rs;
              wb_sel = WB_ALU;
              alu_op = dec.imm4[1:0];
            end
            default: sw = dec.rs;
          endcase
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: per-instruction expansion model checked every cycle, directed scenarios plus random stream.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [9:0] imem_rdata = '0;
  logic [1:0] sw, alu_op, wb_sel, wb_rd;
  logic       opa_ld, reg_we, halted;
  logic [9:0] imm;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.PC_W(8), .IW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .sw(sw), .opa_ld(opa_ld), .alu_op(alu_op), .wb_sel(wb_sel),
    .wb_rd(wb_rd), .reg_we(reg_we), .imm(imm), .halted(halted)
  );

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic [1:0] sw;
    logic       opa_ld;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic [1:0] wb_rd;
    logic       reg_we;
    logic [9:0] imm;
    logic       halted;
  } exp_t;

  // Model: each accepted instruction expands into its list of post-fetch cycles.
  exp_t       q[$];
  logic [7:0] mpc  = '0;
  logic       mhalt = 1'b0;
  logic [9:0] mir  = '0;

  task automatic expand(input logic [9:0] d);
    exp_t dc, ex, wb;
    logic [1:0] op, rd, rs;
    op = d[9:8]; rd = d[7:6]; rs = d[5:4];
    mir = d;
    mpc = mpc + 8'd1;
    dc = '0; dc.addr = mpc;
    q.push_back(dc);
    wb = dc; wb.reg_we = 1'b1; wb.wb_rd = rd;
    case (op)
      2'd0: begin wb.sw = rs; wb.wb_sel = 2'd0; q.push_back(wb); end
      2'd1: begin wb.sw = 2'd0; wb.wb_sel = 2'd1; q.push_back(wb); end
      2'd2: begin
        ex = dc; ex.sw = rd; ex.opa_ld = 1'b1;
        q.push_back(ex);
        wb.sw = rs; wb.wb_sel = 2'd2; wb.alu_op = d[1:0];
        q.push_back(wb);
      end
      default: begin
        if (rd == 2'd3 && rs == 2'd3) mhalt = 1'b1;
        else mpc = d[7:0];
      end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e, got;
    if (!rst_n) e = '0;
    else if (q.size() > 0) e = q[0];
    else begin
      e = '0; e.addr = mpc;
      if (mhalt) e.halted = 1'b1; else e.req = 1'b1;
    end
    if (rst_n) e.imm = {6'b0, mir[3:0]};
    got = {imem_req, imem_addr, sw, opa_ld, alu_op, wb_sel, wb_rd, reg_we, imm, halted};
    chk_cnt++;
    if (got === e) pass_cnt++;
    else $display("FAIL model_cycle t=%0t got req=%b addr=%h sw=%h opa=%b alu=%h wbs=%h rd=%h we=%b imm=%h h=%b exp req=%b addr=%h sw=%h opa=%b alu=%h wbs=%h rd=%h we=%b imm=%h h=%b",
                  $time, got.req, got.addr, got.sw, got.opa_ld, got.alu_op, got.wb_sel, got.wb_rd, got.reg_we, got.imm, got.halted,
                  e.req, e.addr, e.sw, e.opa_ld, e.alu_op, e.wb_sel, e.wb_rd, e.reg_we, e.imm, e.halted);
    if (!rst_n) begin
      q.delete(); mpc = '0; mhalt = 1'b0; mir = '0;
    end else if (q.size() > 0) void'(q.pop_front());
    else if (!mhalt && imem_ack) expand(imem_rdata);
  end

  task automatic chk(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic cyc(input logic r, input logic a, input logic [9:0] d);
    @(posedge clk); #1;
    rst_n = r; imem_ack = a; imem_rdata = d;
    @(negedge clk); #1;
  endtask

  localparam logic [9:0] I_LDI = 10'b01_10_00_0101;
  localparam logic [9:0] I_ALU = 10'b10_01_11_0001;
  localparam logic [9:0] I_JMP = 10'b11_00_10_0011;
  localparam logic [9:0] I_JEF = 10'b11_11_10_1111;
  localparam logic [9:0] I_MOV = 10'b00_01_10_0000;
  localparam logic [9:0] I_HLT = 10'b11_11_11_0000;

  initial begin
    repeat (3) cyc(1'b0, 1'b0, '0);
    chk("rst_outputs", {imem_req, imem_addr, sw, opa_ld, reg_we, halted, imm}, 0);

    // LDI C,5
    cyc(1'b1, 1'b1, I_LDI);
    chk("ldi_fetch_req", imem_req, 1);
    chk("ldi_fetch_addr", imem_addr, 0);
    cyc(1'b1, 1'b0, '0);
    chk("ldi_decode_req", imem_req, 0);
    cyc(1'b1, 1'b0, '0);
    chk("ldi_wb", {reg_we, wb_rd, wb_sel, imm}, {1'b1, 2'b10, 2'b01, 10'd5});

    // ALU B <= B - D
    cyc(1'b1, 1'b1, I_ALU);
    chk("alu_fetch_addr", imem_addr, 1);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("alu_exec", {sw, opa_ld, reg_we}, {2'b01, 1'b1, 1'b0});
    cyc(1'b1, 1'b0, '0);
    chk("alu_wb", {sw, alu_op, wb_sel, reg_we, wb_rd, opa_ld}, {2'b11, 2'b01, 2'b10, 1'b1, 2'b01, 1'b0});

    // Fetch stall, then JMP 0x23
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 10'h3FF);
      chk("stall_req_addr", {imem_req, imem_addr}, {1'b1, 8'd2});
    end
    cyc(1'b1, 1'b1, I_JMP);
    chk("jmp_fetch", {imem_req, imem_addr}, {1'b1, 8'd2});
    cyc(1'b1, 1'b0, '0);
    chk("jmp_decode_req", imem_req, 0);
    cyc(1'b1, 1'b1, I_JEF);
    chk("jmp_target", {imem_req, imem_addr}, {1'b1, 8'h23});
    cyc(1'b1, 1'b0, '0);

    // MOVs from 0xEF through 0xFF, then pc wraps
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b1, I_MOV);
      chk("mov_addr", imem_addr, 8'hEF + i);
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
    end
    cyc(1'b1, 1'b0, '0);
    chk("pc_wrap", {imem_req, imem_addr}, {1'b1, 8'h00});

    // HALT, then reset pulse
    cyc(1'b1, 1'b1, I_HLT);
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 10'($urandom));
      chk("halt_hold", {halted, imem_req}, {1'b1, 1'b0});
    end
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("halt_reset", {halted, imem_req, imem_addr}, {1'b0, 1'b1, 8'd0});

    // Reset during EXEC_A drops the write
    cyc(1'b1, 1'b1, I_ALU);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("abort_exec_zero", {opa_ld, reg_we}, 0);
    cyc(1'b1, 1'b0, '0);
    chk("abort_restart", {imem_req, imem_addr, reg_we}, {1'b1, 8'd0, 1'b0});
    cyc(1'b1, 1'b0, '0);
    chk("abort_no_we", reg_we, 0);

    for (int i = 0; i < 4000; i++)
      cyc(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), 10'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
